// File: rtl/io_irq_bridge_pkg.sv
// Shared definitions for the I/O interrupt bridge: FSM encoding and default byte width.
package io_irq_bridge_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StWaitAck = 2'd2
  } irq_state_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Small synchronous FIFO; head shows the oldest entry, or the last popped byte once empty.
module io_sync_fifo
  import io_irq_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = empty ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/io_irq_bridge.sv
// Peripheral-side bridge for processor data_in/data_out/interrupt pins.
// Optional interrupt request counter enabled by defining IO_IRQ_COUNT_EN.
module io_irq_bridge
  import io_irq_bridge_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned IRQ_WIDTH   = 2,
  parameter int unsigned ACK_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ext_in_data,
  input  logic             ext_in_valid,
  output logic             ext_in_ready,
  output logic [WIDTH-1:0] data_in,
  output logic             interrupt,
  input  logic             cpu_ack,
  input  logic [WIDTH-1:0] data_out,
  input  logic             cpu_wr,
  output logic [WIDTH-1:0] ext_out_data,
  output logic             ext_out_valid,
  input  logic             ext_out_ready,
  output logic             ovf,
  output logic [7:0]       irq_count
);

  localparam int unsigned CntMax = (IRQ_WIDTH > ACK_TIMEOUT) ? IRQ_WIDTH : ACK_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  irq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign ext_in_ready = !fifo_full;
  assign fifo_push    = ext_in_valid && ext_in_ready;

  io_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (ext_in_data),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (data_in)
  );

  // cnt_q is the hold counter in StReq and the ack timeout in StWaitAck.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StReq;
          cnt_d   = CntW'(IRQ_WIDTH);
        end
      end
      StReq: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StWaitAck;
          cnt_d   = CntW'(ACK_TIMEOUT);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWaitAck: begin
        // An ack in the expiry cycle still wins over the retry.
        if (cpu_ack) begin
          fifo_pop = 1'b1;
          state_d  = StIdle;
        end else if (cnt_q <= CntW'(1)) begin
          state_d = StReq;
          cnt_d   = CntW'(IRQ_WIDTH);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign interrupt = (state_q == StReq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_out_data  <= '0;
      ext_out_valid <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      if (cpu_wr) begin
        ext_out_data  <= data_out;
        ext_out_valid <= 1'b1;
        if (ext_out_valid && !ext_out_ready) begin
          ovf <= 1'b1;
        end
      end else if (ext_out_valid && ext_out_ready) begin
        ext_out_valid <= 1'b0;
      end
    end
  end

`ifdef IO_IRQ_COUNT_EN
  logic       irq_enter;
  logic [7:0] irq_count_q;

  assign irq_enter = (state_d == StReq) && (state_q != StReq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_count_q <= '0;
    end else if (irq_enter && (irq_count_q != 8'hFF)) begin
      irq_count_q <= irq_count_q + 8'd1;
    end
  end

  assign irq_count = irq_count_q;
`else
  assign irq_count = '0;
`endif

endmodule

// File: tb/tb_io_irq_bridge.sv
// Scoreboard bench for io_irq_bridge: queued expected bytes checked as the DUT presents them.
module tb_io_irq_bridge;

`ifdef IO_IRQ_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic       clk, reset;
  logic [7:0] ext_in_data, data_in, data_out, ext_out_data, irq_count;
  logic       ext_in_valid, ext_in_ready, interrupt, cpu_ack, cpu_wr;
  logic       ext_out_valid, ext_out_ready, ovf;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int exp_irq    = 0;
  logic [7:0] exp_q[$];
  logic [7:0] out_q[$];

  io_irq_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .data_in       (data_in),
    .interrupt     (interrupt),
    .cpu_ack       (cpu_ack),
    .data_out      (data_out),
    .cpu_wr        (cpu_wr),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .ovf           (ovf),
    .irq_count     (irq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard push: every byte the bridge accepts is expected on data_in in order.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && ext_in_valid && ext_in_ready) exp_q.push_back(ext_in_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_count();
    return CountEn ? 8'(exp_irq) : 8'd0;
  endfunction

  task automatic push_one(input logic [7:0] b);
    ext_in_data  = b;
    ext_in_valid = 1'b1;
    step();
    ext_in_valid = 1'b0;
  endtask

  task automatic ack_now(input string tag);
    logic [7:0] want;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s scoreboard: got empty queue, want a pending byte", tag);
      want = 8'h00;
    end else begin
      want = exp_q.pop_front();
    end
    vectors++;
    if (data_in !== want) begin
      miscompares++;
      $display("FAIL %s head: data_in=%h want %h", tag, data_in, want);
    end
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    vectors++;
    if (interrupt !== 1'b0) begin
      miscompares++;
      $display("FAIL %s gap: interrupt=%b want 0 after ack", tag, interrupt);
    end
  endtask

  task automatic service(input string tag);
    int n;
    n = 0;
    while (interrupt !== 1'b1 && n < 60) begin step(); n++; end
    vectors++;
    if (interrupt !== 1'b1) begin
      miscompares++;
      $display("FAIL %s rise: interrupt=%b want 1 within 60 cycles", tag, interrupt);
    end
    n = 0;
    while (interrupt === 1'b1 && n < 10) begin step(); n++; end
    vectors++;
    if (interrupt !== 1'b0) begin
      miscompares++;
      $display("FAIL %s fall: interrupt=%b want 0 within 10 cycles", tag, interrupt);
    end
    ack_now(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1; ext_in_data = '0; ext_in_valid = 1'b0; cpu_ack = 1'b0;
    data_out = '0; cpu_wr = 1'b0; ext_out_ready = 1'b0;
    #12;
    vectors++;
    if ({data_in, interrupt, ext_in_ready, ext_out_data, ext_out_valid, ovf, irq_count} !==
        {8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state: din=%h irq=%b rdy=%b odat=%h oval=%b ovf=%b cnt=%h want 00 0 1 00 0 0 00",
               data_in, interrupt, ext_in_ready, ext_out_data, ext_out_valid, ovf, irq_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [3:0] want_irq;
    logic [3:0] got_irq;
    push_one(8'h3C);
    vectors++;
    if (data_in !== 8'h3C) begin
      miscompares++;
      $display("FAIL single_visible: data_in=%h want 3c", data_in);
    end
    got_irq[3] = interrupt;
    step(); got_irq[2] = interrupt;
    step(); got_irq[1] = interrupt;
    step(); got_irq[0] = interrupt;
    want_irq = 4'b0110;
    vectors++;
    if (got_irq !== want_irq) begin
      miscompares++;
      $display("FAIL single_pulse: interrupt trace=%b want %b", got_irq, want_irq);
    end
    step(); step();
    ack_now("single_ack");
    exp_irq = 1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (interrupt !== 1'b0) begin
        miscompares++;
        $display("FAIL single_low: interrupt=%b want 0 at cycle %0d after ack", interrupt, i);
      end
      step();
    end
    vectors++;
    if (data_in !== 8'h3C || ext_in_ready !== 1'b1 || irq_count !== exp_count()) begin
      miscompares++;
      $display("FAIL single_hold: din=%h rdy=%b cnt=%h want 3c 1 %h",
               data_in, ext_in_ready, irq_count, exp_count());
    end
  endtask

  task automatic test_fill();
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      ext_in_data  = bytes[i];
      ext_in_valid = 1'b1;
      step();
      if (i == 2) begin
        vectors++;
        if (interrupt !== 1'b1) begin
          miscompares++;
          $display("FAIL fill_irq: interrupt=%b want 1 while filling", interrupt);
        end
      end
    end
    ext_in_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ext_in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_full: ext_in_ready=%b want 0 (cycle %0d)", ext_in_ready, i);
      end
      step();
    end
    ack_now("fill_0");
    vectors++;
    if (ext_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_space: ext_in_ready=%b want 1 after pop", ext_in_ready);
    end
    step();
    ext_in_valid = 1'b0;
    service("fill_1");
    service("fill_2");
    service("fill_3");
    service("fill_4");
    exp_irq += 5;
    vectors++;
    if (irq_count !== exp_count() || data_in !== 8'h55) begin
      miscompares++;
      $display("FAIL fill_end: cnt=%h din=%h want %h 55", irq_count, data_in, exp_count());
    end
  endtask

  task automatic test_ack_in_req();
    int n;
    push_one(8'h5A);
    n = 0;
    while (interrupt !== 1'b1 && n < 10) begin step(); n++; end
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    vectors++;
    if (interrupt !== 1'b1 || data_in !== 8'h5A) begin
      miscompares++;
      $display("FAIL ack_in_req: irq=%b din=%h want 1 5a", interrupt, data_in);
    end
    service("ack_in_req_svc");
    exp_irq += 1;
  endtask

  task automatic test_retry();
    int n, width, rise, prev_rise;
    push_one(8'hA5);
    prev_rise = 0;
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (interrupt !== 1'b1 && n < 60) begin step(); n++; end
      rise = cyc;
      vectors++;
      if (interrupt !== 1'b1) begin
        miscompares++;
        $display("FAIL retry_rise%0d: interrupt=%b want 1 within 60 cycles", p, interrupt);
      end
      if (p > 0) begin
        vectors++;
        if (rise - prev_rise != 34) begin
          miscompares++;
          $display("FAIL retry_period%0d: period=%0d want 34", p, rise - prev_rise);
        end
      end
      prev_rise = rise;
      width = 0;
      while (interrupt === 1'b1 && width < 10) begin step(); width++; end
      vectors++;
      if (width != 2) begin
        miscompares++;
        $display("FAIL retry_width%0d: width=%0d want 2", p, width);
      end
    end
    exp_irq += 3;
    vectors++;
    if (irq_count !== exp_count() || data_in !== 8'hA5) begin
      miscompares++;
      $display("FAIL retry_state: cnt=%h din=%h want %h a5", irq_count, data_in, exp_count());
    end
    ack_now("retry_ack");
  endtask

  task automatic test_out_accept();
    ext_out_ready = 1'b0;
    data_out = 8'h99; cpu_wr = 1'b1; out_q.push_back(8'h99);
    step();
    cpu_wr = 1'b0;
    vectors++;
    if (ext_out_valid !== 1'b1 || ext_out_data !== out_q[0]) begin
      miscompares++;
      $display("FAIL out_first: val=%b dat=%h want 1 %h", ext_out_valid, ext_out_data, out_q[0]);
    end
    data_out = 8'h55; cpu_wr = 1'b1; ext_out_ready = 1'b1;
    void'(out_q.pop_front());
    out_q.push_back(8'h55);
    step();
    cpu_wr = 1'b0; ext_out_ready = 1'b0;
    vectors++;
    if (ext_out_valid !== 1'b1 || ext_out_data !== out_q[0] || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL out_same_cycle: val=%b dat=%h ovf=%b want 1 %h 0",
               ext_out_valid, ext_out_data, ovf, out_q[0]);
    end
    ext_out_ready = 1'b1;
    void'(out_q.pop_front());
    step();
    ext_out_ready = 1'b0;
    vectors++;
    if (ext_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL out_drain: val=%b want 0", ext_out_valid);
    end
  endtask

  task automatic test_ovf();
    data_out = 8'h7E; cpu_wr = 1'b1; out_q.push_back(8'h7E);
    step();
    cpu_wr = 1'b0;
    vectors++;
    if (ext_out_valid !== 1'b1 || ext_out_data !== out_q[0] || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_first: val=%b dat=%h ovf=%b want 1 %h 0",
               ext_out_valid, ext_out_data, ovf, out_q[0]);
    end
    data_out = 8'h81; cpu_wr = 1'b1;
    void'(out_q.pop_front());
    out_q.push_back(8'h81);
    step();
    cpu_wr = 1'b0;
    vectors++;
    if (ext_out_data !== out_q[0] || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_overwrite: dat=%h ovf=%b want %h 1", ext_out_data, ovf, out_q[0]);
    end
    ext_out_ready = 1'b1;
    void'(out_q.pop_front());
    step();
    ext_out_ready = 1'b0;
    vectors++;
    if (ext_out_valid !== 1'b0 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky: val=%b ovf=%b want 0 1", ext_out_valid, ovf);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    ext_in_data = 8'h01; ext_in_valid = 1'b1;
    step();
    ext_in_data = 8'h02;
    step();
    ext_in_valid = 1'b0;
    n = 0;
    while (interrupt !== 1'b1 && n < 10) begin step(); n++; end
    vectors++;
    if (interrupt !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre: interrupt=%b want 1 before reset", interrupt);
    end
    reset = 1'b1;
    #2;
    vectors++;
    if (interrupt !== 1'b0 || ext_in_ready !== 1'b1 || data_in !== 8'h00 ||
        irq_count !== 8'h00 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: irq=%b rdy=%b din=%h cnt=%h ovf=%b want 0 1 00 00 0",
               interrupt, ext_in_ready, data_in, irq_count, ovf);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_irq = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (interrupt !== 1'b0 || data_in !== 8'h00) begin
        miscompares++;
        $display("FAIL rst_mid_empty: irq=%b din=%h want 0 00 (cycle %0d)", interrupt, data_in, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_ack_in_req();
    test_retry();
    test_out_accept();
    test_ovf();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_irq_bridge.md
Name: io_irq_bridge

Overview:
- Peripheral-side counterpart of the processor's data_in / data_out / interrupt pins.
- Buffers bytes from an external device in a small FIFO and presents the head byte on the processor's data_in.
- Raises the processor interrupt and retries on timeout until the ISR acknowledges.
- Captures processor output bytes into a one-entry holding register for the external device.

Parameters:
DEPTH, 4, input FIFO entries (power of two, 2..16)
WIDTH, 8, byte width; matches processor data_in/data_out
IRQ_WIDTH, 2, cycles interrupt is held high per request
ACK_TIMEOUT, 32, cycles to wait for cpu_ack before re-raising interrupt

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ext_in_data  input  WIDTH  byte from external device
ext_in_valid  input  1  ext_in_data valid
ext_in_ready  output  1  FIFO not full
data_in  output  WIDTH  FIFO head, wired to processor data_in
interrupt  output  1  wired to processor interrupt
cpu_ack  input  1  one-cycle pulse from the ISR: head consumed
data_out  input  WIDTH  processor data_out
cpu_wr  input  1  one-cycle strobe: capture data_out
ext_out_data  output  WIDTH  captured processor byte
ext_out_valid  output  1  ext_out_data valid
ext_out_ready  input  1  external device accepts ext_out_data
ovf  output  1  sticky: cpu_wr while ext_out_valid and no same-cycle accept
irq_count  output  8  interrupt request count (see Optional Feature)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high, port names clk and reset.
- Reset values: FIFO empty, pointers 0, data_in=0, interrupt=0, ext_in_ready=1, ext_out_data=0, ext_out_valid=0, ovf=0, irq_count=0, FSM=IDLE.
- FIFO push: on ext_in_valid && ext_in_ready. Push into an empty FIFO becomes visible on data_in the next cycle.
- data_in: shows the head entry; holds the last popped value when the FIFO is empty.
- FIFO pop: only on cpu_ack in WAIT_ACK state. cpu_ack in any other state is ignored (no pop, no error).
- Full FIFO: ext_in_ready=0. Same-cycle push+pop when full is allowed; ext_in_ready is combinational from the count.
- Pointer arithmetic: log2(DEPTH)-bit pointers wrap naturally. Count is log2(DEPTH)+1 bits.
- FSM IDLE: leave when FIFO non-empty; enter REQ, load hold counter with IRQ_WIDTH.
- FSM REQ: interrupt=1; count down. At 0, enter WAIT_ACK with timeout counter loaded to ACK_TIMEOUT.
- FSM WAIT_ACK: interrupt=0.
  - On cpu_ack: pop, go to IDLE. IDLE re-raises next cycle if the FIFO is still non-empty, so there is a minimum 1-cycle low gap between requests.
  - On timeout reaching 0 without ack: go to REQ (retry), head unchanged.
- cpu_ack and timeout expiry in the same cycle: ack wins.
- cpu_ack arriving during REQ: ignored; the ISR must ack after interrupt falls.
- Output capture on cpu_wr: ext_out_data<=data_out, ext_out_valid<=1.
  - ext_out_valid && ext_out_ready clears valid.
  - cpu_wr and accept in the same cycle: new byte is loaded, valid stays 1, no overflow.
  - cpu_wr while valid without accept: the byte is overwritten and ovf is set. ovf clears only on reset.
- Reset mid-request: interrupt drops immediately (asynchronous) and FIFO contents are discarded.

Optional Feature:
- Macro IO_IRQ_COUNT_EN.
- Defined: irq_count increments on every IDLE->REQ or WAIT_ACK->REQ transition, saturating at 255.
- Undefined: counter logic is absent and irq_count is tied to 0.

Decomposition:
- Shared package holds the FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT_ACK=2'd2) and the default WIDTH constant.
- One natural sub-module, io_sync_fifo: parameterised DEPTH/WIDTH, push/pop/full/empty/head.
- FSM, output holding register and counter stay in the top.

Test Plan:
- Reset, then push 0x3C: data_in=0x3C next cycle; interrupt high for exactly 2 cycles after FSM leaves IDLE; cpu_ack 3 cycles later pops, interrupt stays low.
- Push 0x11,0x22,0x33,0x44 with no ack: ext_in_ready=0 after the 4th push. Fifth push is held. Ack sequence yields data_in 0x11->0x22->0x33->0x44 with a new interrupt before each ack.
- Push 0xA5 and never ack: interrupt re-pulses every 2+32 cycles; with IO_IRQ_COUNT_EN, irq_count=3 after the third pulse; data_in stays 0xA5.
- cpu_wr with data_out=0x7E, ext_out_ready=0: ext_out_valid=1, ext_out_data=0x7E. Second cpu_wr with 0x81: ext_out_data=0x81, ovf=1.
- cpu_wr with 0x55 in the same cycle as the accept of the previous byte: ext_out_valid stays 1, ext_out_data=0x55, ovf stays 0.
- Assert reset during REQ with 2 entries queued: interrupt=0 before the next clock edge, ext_in_ready=1, FIFO empty, irq_count=0.
